// File: rtl/inv_key_expand.sv
// inv_key_expand: AES-128 inverse key schedule, rebuilds w[0..43] backwards from the round-10 key
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset, clears FSM and storage
//   start         : one-cycle pulse, begins (or restarts) loading w[40..43]
//   last_key      : round-10 key word stream, w[40] first
//   r_index       : word index within the selected round key
//   round_key_num : round key select 0..10, larger values read as zero
//   round_key     : combinational read of w[4*round_key_num + r_index]
//   done          : all 44 words valid, held until next start or reset
module inv_key_expand #(
   parameter int NR = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] last_key,
   input  logic [1:0]  r_index,
   input  logic [3:0]  round_key_num,
   output logic [31:0] round_key,
   output logic        done
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };
   // indexed by i/4; entries 0 and 11..15 never selected in EXPAND
   localparam logic [7:0] RCON [16] = '{
      8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
      8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00
   };

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [5:0]  i_q, i_d;
   logic [31:0] w_q [44];
   logic        we;
   logic [5:0]  waddr;
   logic [31:0] wdata, prev, rot, sub, t;

   // backward step: w[i-4] = w[i] ^ t(w[i-1]), mirroring the forward recurrence
   always_comb begin
      prev = w_q[i_q - 6'd1];
      rot  = {prev[23:0], prev[31:24]};
      sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
      t    = (i_q[1:0] == 2'd0) ? (sub ^ {RCON[i_q[5:2]], 24'h0}) : prev;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      i_d     = i_q;
      we      = 1'b0;
      waddr   = 6'd0;
      wdata   = 32'h0;
      if (start) begin
         // start aborts anything in flight, including the final EXPAND step
         state_d = LOAD;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            LOAD: begin
               we      = 1'b1;
               waddr   = 6'd40 + {4'd0, cnt_q};
               wdata   = last_key;
               cnt_d   = cnt_q + 2'd1;
               state_d = (cnt_q == 2'd3) ? EXPAND : LOAD;
               i_d     = (cnt_q == 2'd3) ? 6'd43 : i_q;
            end
            EXPAND: begin
               we      = 1'b1;
               waddr   = i_q - 6'd4;
               wdata   = w_q[i_q] ^ t;
               i_d     = i_q - 6'd1;
               state_d = (i_q == 6'd4) ? DONE : EXPAND;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         i_q     <= 6'd0;
         for (int k = 0; k < 44; k++) w_q[k] <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         i_q     <= i_d;
         if (we) w_q[waddr] <= wdata;
      end
   end

   assign done      = (state_q == DONE);
   assign round_key = (round_key_num <= 4'(NR)) ? w_q[{round_key_num, r_index}] : 32'h0;
endmodule

// File: tb/tb_inv_key_expand.sv
// tb_inv_key_expand: scoreboard bench for inv_key_expand
module tb_inv_key_expand;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [31:0] last_key = 32'h0;
   logic [1:0]  r_index = 2'd0;
   logic [3:0]  round_key_num = 4'd0;
   logic [31:0] round_key;
   logic        done;
   int          passed = 0, total = 0;

   localparam logic [127:0] FIPS = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] ZKEY = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

   typedef struct {
      logic [3:0]  rn;
      logic [1:0]  ri;
      logic [31:0] v;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   inv_key_expand dut (
      .clk(clk), .reset(reset), .start(start), .last_key(last_key),
      .r_index(r_index), .round_key_num(round_key_num),
      .round_key(round_key), .done(done)
   );

   task tick;
      @(posedge clk);
      #1;
   endtask

   task push_round(input logic [3:0] rn, input logic [127:0] k);
      for (int j = 0; j < 4; j++) begin
         exp_t e;
         e.rn = rn;
         e.ri = 2'(j);
         e.v  = k[127 - 32*j -: 32];
         sb.push_back(e);
      end
   endtask

   task push_fips;
      push_round(4'd0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
      push_round(4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      push_round(4'd9,  128'hac7766f3_19fadc21_28d12941_575c006e);
      push_round(4'd10, FIPS);
   endtask

   task push_zero;
      push_round(4'd0,  128'h0);
      push_round(4'd1,  128'h62636363_62636363_62636363_62636363);
      push_round(4'd10, ZKEY);
   endtask

   task drain(input string tag);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         round_key_num = e.rn;
         r_index = e.ri;
         #1;
         total++;
         if (round_key !== e.v)
            $display("FAIL %s rk[%0d][%0d] got %h expected %h", tag, e.rn, e.ri, round_key, e.v);
         else passed++;
      end
   endtask

   task load(input logic [127:0] k, input string tag);
      start = 1'b1;
      tick;
      start = 1'b0;
      total++;
      if (done !== 1'b0) $display("FAIL %s done_drop got %b expected 0", tag, done);
      else passed++;
      for (int j = 0; j < 4; j++) begin
         last_key = k[127 - 32*j -: 32];
         tick;
      end
      last_key = 32'h0;
   endtask

   task wait_done(input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         tick;
         n++;
      end
      total++;
      if (n != 40) $display("FAIL %s latency got %0d expected 40 edges after load", tag, n);
      else passed++;
   endtask

   task test_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      total++;
      if (done !== 1'b0) $display("FAIL reset done got %b expected 0", done);
      else passed++;
      for (int r = 0; r <= 10; r++) push_round(4'(r), 128'h0);
      drain("reset");
   endtask

   task test_fips;
      load(FIPS, "fips");
      wait_done("fips");
      push_fips;
      drain("fips");
   endtask

   task test_zero;
      load(ZKEY, "zero");
      wait_done("zero");
      push_zero;
      drain("zero");
   endtask

   task test_abort;
      load(FIPS, "abort1");
      for (int j = 0; j < 10; j++) tick;
      total++;
      if (done !== 1'b0) $display("FAIL abort early_done got %b expected 0", done);
      else passed++;
      load(ZKEY, "abort2");
      wait_done("abort");
      push_zero;
      drain("abort");
   endtask

   task test_reset_mid;
      load(FIPS, "rstmid");
      for (int j = 0; j < 15; j++) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      total++;
      if (done !== 1'b0) $display("FAIL rstmid done got %b expected 0", done);
      else passed++;
      for (int r = 0; r <= 10; r++) push_round(4'(r), 128'h0);
      drain("rstmid_clear");
      test_fips;
   endtask

   task test_rerun;
      test_fips;
      test_zero;
      test_fips;
   endtask

   task test_out_of_range;
      exp_t e;
      for (int r = 11; r < 16; r++)
         for (int j = 0; j < 4; j++) begin
            e.rn = 4'(r);
            e.ri = 2'(j);
            e.v  = 32'h0;
            sb.push_back(e);
         end
      push_fips;
      drain("oor");
      total++;
      if (done !== 1'b1) $display("FAIL oor done got %b expected 1", done);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_fips;
      test_zero;
      test_abort;
      test_reset_mid;
      test_rerun;
      test_out_of_range;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
